mcp_spi_arb: RTL and testbench

- Two-requester round-robin arbiter plus SPI master (mode 0, MSB first) that issues single-byte MCP23S17-style transactions.
- Each frame is 3 bytes: opcode (0x40 | HW_ADDR<<1 | rw), register address, data byte (written, or read back on miso).
- Sits between on-chip control logic and the SPI sink / external expander.
- Generates sclk_o, csn_o and mosi_o from the system clock; samples miso_i.

---
 rtl/mcp_spi_pkg.sv | 18 +
 rtl/spi_master_phy.sv | 102 ++++++++++
 rtl/mcp_spi_arb.sv | 126 ++++++++++++
 tb/tb_mcp_spi_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_spi_pkg.sv
// Shared types and constants for the MCP23S17-style SPI arbiter and its PHY.
package mcp_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    localparam logic [3:0]  MCP_OPCODE_BASE = 4'b0100;
    localparam int unsigned FRAME_BITS      = 24;

    function automatic logic [7:0] mcp_opcode(input logic [2:0] hw_addr, input logic rw);
        return {MCP_OPCODE_BASE, hw_addr, rw};
    endfunction

endpackage

// File: rtl/spi_master_phy.sv
// Mode-0 SPI master PHY: SETUP/SHIFT timing, sclk divider, 24-bit shifter, miso capture.
module spi_master_phy
    import mcp_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  done,
    output logic [7:0]            rx,
    output logic                  sclk,
    output logic                  csn,
    output logic                  mosi,
    input  logic                  miso
);

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            div_cnt;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] sreg;
    logic [7:0]            rx_sreg;
    logic                  div_end;

    assign div_end = (div_cnt == 8'(CLK_DIV - 1));
    assign rx      = rx_sreg;

    // done marks the last low cycle of bit 0; csn rises on the same edge.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = SETUP;
            SETUP: if (div_end) state_nxt = SHIFT;
            SHIFT: begin
                if (div_end && !sclk && (bit_cnt == '0)) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sclk    <= 1'b0;
            csn     <= 1'b1;
            mosi    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            rx_sreg <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        csn     <= 1'b0;
                        sclk    <= 1'b0;
                        mosi    <= frame[FRAME_BITS-1];
                        sreg    <= {frame[FRAME_BITS-2:0], 1'b0};
                        div_cnt <= '0;
                        bit_cnt <= 5'(FRAME_BITS - 1);
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (sclk) begin
                            // Falling transition: capture miso, present the next bit.
                            sclk    <= 1'b0;
                            rx_sreg <= {rx_sreg[6:0], miso};
                            mosi    <= sreg[FRAME_BITS-1];
                            sreg    <= {sreg[FRAME_BITS-2:0], 1'b0};
                        end else if (bit_cnt == '0) begin
                            csn <= 1'b1;
                        end else begin
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mcp_spi_arb.sv
// Two-requester round-robin arbiter issuing 3-byte MCP23S17 SPI frames.
// Optional ack counters are enabled with `define MCP_SPI_ARB_CNT_EN.
module mcp_spi_arb
    import mcp_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [2:0]  HW_ADDR  = 3'b000,
    parameter int unsigned CSN_IDLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_i,
    input  logic       rw0_i,
    input  logic [7:0] addr0_i,
    input  logic [7:0] wdata0_i,
    output logic       ack0_o,
    input  logic       req1_i,
    input  logic       rw1_i,
    input  logic [7:0] addr1_i,
    input  logic [7:0] wdata1_i,
    output logic       ack1_o,
    output logic [7:0] rdata_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       csn_o,
    output logic       mosi_o,
    input  logic       miso_i
`ifdef MCP_SPI_ARB_CNT_EN
    ,
    output logic [15:0] cnt0_o,
    output logic [15:0] cnt1_o
`endif
);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       rw_lat;
    logic [15:0] gap_cnt;
    logic       any_req;
    logic       gnt_sel;
    logic       rw_sel;
    logic [7:0] addr_sel;
    logic [7:0] wdata_sel;
    logic       phy_start;
    logic       phy_done;
    logic [7:0] phy_rx;

    assign any_req   = req0_i | req1_i;
    // With both requesting, the one not served last wins; otherwise the lone requester.
    assign gnt_sel   = (req0_i && req1_i) ? ~last_grant : req1_i;
    assign rw_sel    = gnt_sel ? rw1_i    : rw0_i;
    assign addr_sel  = gnt_sel ? addr1_i  : addr0_i;
    assign wdata_sel = gnt_sel ? wdata1_i : wdata0_i;
    assign phy_start = (state == IDLE) && any_req;

    spi_master_phy #(
        .CLK_DIV(CLK_DIV)
    ) u_phy (
        .clk   (clk),
        .rst_n (rst_n),
        .start (phy_start),
        .frame ({mcp_opcode(HW_ADDR, rw_sel), addr_sel, wdata_sel}),
        .done  (phy_done),
        .rx    (phy_rx),
        .sclk  (sclk_o),
        .csn   (csn_o),
        .mosi  (mosi_o),
        .miso  (miso_i)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any_req) state_nxt = SHIFT;
            SHIFT: if (phy_done) state_nxt = GAP;
            GAP:   if (gap_cnt == 16'(CSN_IDLE - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rw_lat     <= 1'b0;
            gap_cnt    <= '0;
            ack0_o     <= 1'b0;
            ack1_o     <= 1'b0;
            rdata_o    <= '0;
            busy_o     <= 1'b0;
        end else begin
            state  <= state_nxt;
            ack0_o <= 1'b0;
            ack1_o <= 1'b0;
            if (phy_start) begin
                last_grant <= gnt_sel;
                rw_lat     <= rw_sel;
                busy_o     <= 1'b1;
            end
            if (phy_done) begin
                ack0_o  <= ~last_grant;
                ack1_o  <= last_grant;
                rdata_o <= rw_lat ? phy_rx : '0;
                gap_cnt <= '0;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + 16'd1;
                if (state_nxt == IDLE) busy_o <= 1'b0;
            end
        end
    end

`ifdef MCP_SPI_ARB_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0_o <= '0;
            cnt1_o <= '0;
        end else if (phy_done) begin
            if (last_grant) cnt1_o <= cnt1_o + 16'd1;
            else            cnt0_o <= cnt0_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcp_spi_arb.sv
// Self-checking bench for mcp_spi_arb: two instances (CLK_DIV=4/HW=0 and CLK_DIV=2/HW=5) with SPI sink models.
module tb_mcp_spi_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    logic       req0 [2];
    logic       rw0 [2];
    logic [7:0] addr0 [2];
    logic [7:0] wdata0 [2];
    logic       req1 [2];
    logic       rw1 [2];
    logic [7:0] addr1 [2];
    logic [7:0] wdata1 [2];
    logic       ack0 [2];
    logic       ack1 [2];
    logic [7:0] rdata [2];
    logic       busy [2];
    logic       sclk [2];
    logic       csn [2];
    logic       mosi [2];
    logic       miso [2];
`ifdef MCP_SPI_ARB_CNT_EN
    logic [15:0] cnt0 [2];
    logic [15:0] cnt1 [2];
`endif

    // Sink model state
    int          run [2];
    int          hi_run [2];
    int          bit_idx [2];
    int          nrise [2];
    int          nframes [2];
    bit          seen [2];
    logic        prev_csn [2];
    logic        prev_sclk [2];
    logic [23:0] cap [2];
    logic [23:0] last_cap [2];
    logic [23:0] miso_pat [2];
    int          nack [2][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcp_spi_arb #(.CLK_DIV(4), .HW_ADDR(3'b000), .CSN_IDLE(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0[0]), .rw0_i(rw0[0]), .addr0_i(addr0[0]), .wdata0_i(wdata0[0]), .ack0_o(ack0[0]),
        .req1_i(req1[0]), .rw1_i(rw1[0]), .addr1_i(addr1[0]), .wdata1_i(wdata1[0]), .ack1_o(ack1[0]),
        .rdata_o(rdata[0]), .busy_o(busy[0]), .sclk_o(sclk[0]), .csn_o(csn[0]), .mosi_o(mosi[0]),
        .miso_i(miso[0])
`ifdef MCP_SPI_ARB_CNT_EN
        , .cnt0_o(cnt0[0]), .cnt1_o(cnt1[0])
`endif
    );

    mcp_spi_arb #(.CLK_DIV(2), .HW_ADDR(3'b101), .CSN_IDLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0[1]), .rw0_i(rw0[1]), .addr0_i(addr0[1]), .wdata0_i(wdata0[1]), .ack0_o(ack0[1]),
        .req1_i(req1[1]), .rw1_i(rw1[1]), .addr1_i(addr1[1]), .wdata1_i(wdata1[1]), .ack1_o(ack1[1]),
        .rdata_o(rdata[1]), .busy_o(busy[1]), .sclk_o(sclk[1]), .csn_o(csn[1]), .mosi_o(mosi[1]),
        .miso_i(miso[1])
`ifdef MCP_SPI_ARB_CNT_EN
        , .cnt0_o(cnt0[1]), .cnt1_o(cnt1[1])
`endif
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [2:0] hw_of(input int k);
        return (k == 0) ? 3'b000 : 3'b101;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input int r, input logic rq, input logic rw,
                         input logic [7:0] a, input logic [7:0] wd);
        if (r == 0) begin
            req0[k] = rq; rw0[k] = rw; addr0[k] = a; wdata0[k] = wd;
        end else begin
            req1[k] = rq; rw1[k] = rw; addr1[k] = a; wdata1[k] = wd;
        end
    endtask

    // SPI sink: samples sclk/csn/mosi just after each clk edge, checks phase widths, drives miso.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                run[k] = 0; hi_run[k] = 0; bit_idx[k] = 0; nrise[k] = 0; seen[k] = 1'b0;
            end else if (!csn[k]) begin
                if (prev_csn[k]) begin
                    if (seen[k]) chk("csn_gap", 32'(hi_run[k] >= gap_of(k)), 32'd1);
                    run[k] = 1; bit_idx[k] = 0; nrise[k] = 0; cap[k] = '0;
                end else if (sclk[k] != prev_sclk[k]) begin
                    chk("sclk_phase", 32'(run[k]), 32'(div_of(k)));
                    run[k] = 1;
                    if (sclk[k]) begin
                        cap[k] = {cap[k][22:0], mosi[k]};
                        nrise[k]++;
                    end else begin
                        bit_idx[k]++;
                    end
                end else begin
                    run[k]++;
                end
            end else begin
                if (!prev_csn[k]) begin
                    chk("sclk_phase_end", 32'(run[k]), 32'(div_of(k)));
                    chk("sclk_low_at_csn", 32'(prev_sclk[k]), 32'd0);
                    chk("bit_count", 32'(nrise[k]), 32'd24);
                    last_cap[k] = cap[k];
                    nframes[k]++;
                    seen[k] = 1'b1;
                    hi_run[k] = 1;
                end else begin
                    hi_run[k]++;
                end
            end
            prev_csn[k]  = csn[k];
            prev_sclk[k] = sclk[k];
            miso[k] = (!csn[k] && bit_idx[k] < 24) ? miso_pat[k][5'(23 - bit_idx[k])] : 1'b0;
        end
    end

    task automatic issue(input int k, input int r, input logic rw, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] td, input bit drop_mid);
        int d;
        int g;
        int t0;
        int nf0;
        bit got;
        logic [23:0] exp_frame;
        d = div_of(k);
        g = gap_of(k);
        exp_frame = {4'b0100, hw_of(k), rw, a, wd};
        @(negedge clk);
        miso_pat[k] = {16'($urandom), td};
        nf0 = nframes[k];
        drive(k, r, 1'b1, rw, a, wd);
        t0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (cyc == t0 + 1) begin
                chk("busy_start", 32'(busy[k]), 32'd1);
                chk("csn_start", 32'(csn[k]), 32'd0);
                chk("mosi_first", 32'(mosi[k]), 32'(exp_frame[23]));
            end
            if (cyc == t0 + 5) drive(k, r, 1'b1, ~rw, ~a, ~wd);
            if (drop_mid && cyc == t0 + 10) drive(k, r, 1'b0, ~rw, ~a, ~wd);
            if (ack0[k] || ack1[k]) got = 1'b1;
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_latency", 32'(cyc - t0), 32'(1 + 49 * d));
        chk("ack0", 32'(ack0[k]), 32'(r == 0));
        chk("ack1", 32'(ack1[k]), 32'(r == 1));
        chk("rdata", 32'(rdata[k]), 32'(rw ? td : 8'h00));
        chk("frame", 32'(last_cap[k]), 32'(exp_frame));
        chk("nframes", 32'(nframes[k]), 32'(nf0 + 1));
        chk("busy_ack", 32'(busy[k]), 32'd1);
        nack[k][r]++;
        drive(k, r, 1'b0, rw, a, wd);
        for (int i = 1; i < g; i++) begin
            @(negedge clk);
            chk("busy_gap", 32'(busy[k]), 32'd1);
            chk("rdata_hold", 32'(rdata[k]), 32'(rw ? td : 8'h00));
        end
        @(negedge clk);
        chk("busy_idle", 32'(busy[k]), 32'd0);
        chk("csn_idle", 32'(csn[k]), 32'd1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        int tprev;
        int lastg;
        int g;
        bit got;
        bit abort_ack;
        for (int k = 0; k < 2; k++) begin
            drive(k, 0, 1'b0, 1'b0, 8'h00, 8'h00);
            drive(k, 1, 1'b0, 1'b0, 8'h00, 8'h00);
            miso_pat[k] = '0; nframes[k] = 0; last_cap[k] = '0;
            prev_csn[k] = 1'b1; prev_sclk[k] = 1'b0;
            nack[k][0] = 0; nack[k][1] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_csn", 32'(csn[k]), 32'd1);
            chk("rst_sclk", 32'(sclk[k]), 32'd0);
            chk("rst_mosi", 32'(mosi[k]), 32'd0);
            chk("rst_ack", 32'({ack0[k], ack1[k]}), 32'd0);
            chk("rst_rdata", 32'(rdata[k]), 32'd0);
            chk("rst_busy", 32'(busy[k]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(0, 0, 1'b0, 8'h12, 8'hA5, 8'h3C, 1'b0);
        issue(0, 1, 1'b1, 8'h09, 8'h00, 8'hF0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            issue(0, int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom));
        end
        issue(1, 0, 1'b0, 8'h5E, 8'hC3, 8'h00, 1'b0);
        issue(1, 1, 1'b1, 8'($urandom), 8'($urandom), 8'h96, 1'b1);
`ifdef MCP_SPI_ARB_CNT_EN
        chk("cnt0_pre", 32'(cnt0[0]), 32'(nack[0][0]));
        chk("cnt1_pre", 32'(cnt1[0]), 32'(nack[0][1]));
`endif

        // Abort during bit 10 of the shift phase
        @(negedge clk);
        drive(0, 0, 1'b1, 1'b0, 8'h77, 8'h11);
        t0 = cyc;
        while (cyc < t0 + 111) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_csn", 32'(csn[0]), 32'd1);
        chk("abort_sclk", 32'(sclk[0]), 32'd0);
        chk("abort_mosi", 32'(mosi[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_rdata", 32'(rdata[0]), 32'd0);
        rst_n = 1'b1;
        drive(0, 0, 1'b0, 1'b0, 8'h77, 8'h11);
        for (int k = 0; k < 2; k++) begin nack[k][0] = 0; nack[k][1] = 0; end
        abort_ack = 1'b0;
        repeat (250) begin
            @(negedge clk);
            if (ack0[0] || ack1[0]) abort_ack = 1'b1;
        end
        chk("no_ack_after_abort", 32'(abort_ack), 32'd0);

        // Both held: round-robin starting from requester 0 after reset
        @(negedge clk);
        miso_pat[0] = {16'h0000, 8'h6B};
        drive(0, 0, 1'b1, 1'b0, 8'h33, 8'h5A);
        drive(0, 1, 1'b1, 1'b1, 8'h44, 8'h00);
        t0 = cyc;
        tprev = 0;
        lastg = 1;
        for (int f = 0; f < 4; f++) begin
            g = 1 - lastg;
            lastg = g;
            got = 1'b0;
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                if (ack0[0] || ack1[0]) got = 1'b1;
            end
            chk("rr_ack_seen", 32'(got), 32'd1);
            chk("rr_order", 32'({ack1[0], ack0[0]}), (g == 0) ? 32'd1 : 32'd2);
            chk("rr_rdata", 32'(rdata[0]), (g == 0) ? 32'h00 : 32'h6B);
            chk("rr_frame", 32'(last_cap[0]), (g == 0) ? 32'h40335A : 32'h414400);
            if (f == 0) chk("rr_latency", 32'(cyc - t0), 32'd197);
            else        chk("rr_spacing", 32'(cyc - tprev), 32'd201);
            tprev = cyc;
            nack[0][g]++;
            if (f == 3) begin
                drive(0, 0, 1'b0, 1'b0, 8'h33, 8'h5A);
                drive(0, 1, 1'b0, 1'b1, 8'h44, 8'h00);
            end
        end
        repeat (8) @(negedge clk);
        chk("rr_idle_busy", 32'(busy[0]), 32'd0);
`ifdef MCP_SPI_ARB_CNT_EN
        chk("cnt0_post", 32'(cnt0[0]), 32'(nack[0][0]));
        chk("cnt1_post", 32'(cnt1[0]), 32'(nack[0][1]));
        chk("cnt_dut1", 32'({cnt1[1], cnt0[1]}), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
